ctrl_complemento_serie: RTL and testbench

CTRL_COMPLEMENTO_SERIE -- requirements
Module: ctrl_complemento_serie

---
 rtl/ctrl_complemento_serie_pkg.sv | 16 +
 rtl/celda_comp_serie.sv | 16 +
 rtl/ctrl_complemento_serie.sv | 92 +++++++++
 tb/tb_ctrl_complemento_serie.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ctrl_complemento_serie_pkg.sv
// Shared definitions for the serial one's/two's complement controller:
// FSM state encoding, default word width and operation-select encodings.
package ctrl_complemento_serie_pkg;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    DESPLAZA = 2'd1,
    FIN      = 2'd2
  } estado_t;

  localparam int N_DEF = 8;

  localparam logic MODO_UNO = 1'b0;
  localparam logic MODO_DOS = 1'b1;

endpackage

// File: rtl/celda_comp_serie.sv
// Per-bit complement rule: two's complement copies bits up to and including
// the first 1, then inverts; one's complement inverts every bit.
module celda_comp_serie
  import ctrl_complemento_serie_pkg::*;
(
  input  logic i_bit,
  input  logic i_modo,
  input  logic i_visto,
  output logic o_res,
  output logic o_visto
);

  assign o_res   = ((i_modo == MODO_DOS) && !i_visto) ? i_bit : ~i_bit;
  assign o_visto = i_visto | i_bit;

endmodule

// File: rtl/ctrl_complemento_serie.sv
// Serial complement controller: captures an operand on inicio, processes one
// bit per clock LSB first, and presents the registered result after N clocks.
module ctrl_complemento_serie
  import ctrl_complemento_serie_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inicio,
  input  logic         modo,
  input  logic [N-1:0] dato_in,
  output logic         ocupado,
  output logic         listo,
  output logic [N-1:0] dato_out,
  output logic         desborde
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] ULTIMO  = CW'(N - 1);
  localparam logic [N-1:0]  MIN_NEG = {1'b1, {(N-1){1'b0}}};

  estado_t       r_estado;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_sr;
  logic          r_modo;
  logic          r_visto;
  logic          r_desb_pend;
  logic [N-1:0]  r_dato_out;
  logic          r_desborde;

  logic          w_res;
  logic          w_visto;
  logic [N-1:0]  w_sr_next;

  celda_comp_serie u_celda (
    .i_bit   (r_sr[0]),
    .i_modo  (r_modo),
    .i_visto (r_visto),
    .o_res   (w_res),
    .o_visto (w_visto)
  );

  // Operand shifts out of bit 0 while the result shifts in at the MSB,
  // so after N steps the same register holds the finished word.
  assign w_sr_next = {w_res, r_sr[N-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado    <= REPOSO;
      r_cnt       <= '0;
      r_sr        <= '0;
      r_modo      <= MODO_UNO;
      r_visto     <= 1'b0;
      r_desb_pend <= 1'b0;
      r_dato_out  <= '0;
      r_desborde  <= 1'b0;
    end else begin
      case (r_estado)
        REPOSO, FIN: begin
          if (inicio) begin
            r_sr        <= dato_in;
            r_modo      <= modo;
            r_visto     <= 1'b0;
            r_desb_pend <= (modo == MODO_DOS) && (dato_in == MIN_NEG);
            r_cnt       <= '0;
            r_estado    <= DESPLAZA;
          end else begin
            r_estado    <= REPOSO;
          end
        end
        DESPLAZA: begin
          r_sr    <= w_sr_next;
          r_visto <= w_visto;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == ULTIMO) begin
            r_estado   <= FIN;
            r_dato_out <= w_sr_next;
            r_desborde <= r_desb_pend;
          end
        end
        default: r_estado <= REPOSO;
      endcase
    end
  end

  assign ocupado  = (r_estado == DESPLAZA);
  assign listo    = (r_estado == FIN);
  assign dato_out = r_dato_out;
  assign desborde = r_desborde;

endmodule

// File: tb/tb_ctrl_complemento_serie.sv
// Directed bench for ctrl_complemento_serie at N=8 with immediate assertions.
module tb_ctrl_complemento_serie;

  logic       clk;
  logic       rst;
  logic       inicio;
  logic       modo;
  logic [7:0] dato_in;
  logic       ocupado;
  logic       listo;
  logic [7:0] dato_out;
  logic       desborde;

  int checks   = 0;
  int failures = 0;

  ctrl_complemento_serie #(.N(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .inicio   (inicio),
    .modo     (modo),
    .dato_in  (dato_in),
    .ocupado  (ocupado),
    .listo    (listo),
    .dato_out (dato_out),
    .desborde (desborde)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One conversion from REPOSO; full=1 also checks ocupado/listo every busy cycle.
  task automatic conv(input logic [7:0] d, input logic m, input bit full, input string tag);
    logic [7:0] e;
    logic       ed;
    e  = ~d + {7'b0, m};
    ed = m && (d == 8'h80);
    dato_in = d;
    modo    = m;
    inicio  = 1'b1;
    tick();
    inicio  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (full) begin
        chk({tag, "_ocupado_busy"}, ocupado, 1);
        chk({tag, "_listo_busy"}, listo, 0);
      end
      tick();
    end
    chk({tag, "_listo"}, listo, 1);
    chk({tag, "_dato_out"}, dato_out, e);
    chk({tag, "_desborde"}, desborde, ed);
    if (full) chk({tag, "_ocupado_fin"}, ocupado, 0);
    tick();
    chk({tag, "_listo_pulse"}, listo, 0);
    if (full) chk({tag, "_dato_held"}, dato_out, e);
  endtask

  initial begin
    int  cyc;
    bit  seen;
    rst     = 1'b1;
    inicio  = 1'b0;
    modo    = 1'b0;
    dato_in = 8'h00;
    #2;
    chk("rst_ocupado", ocupado, 0);
    chk("rst_listo", listo, 0);
    chk("rst_dato_out", dato_out, 0);
    chk("rst_desborde", desborde, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_ocupado", ocupado, 0);

    conv(8'h06, 1'b1, 1, "neg06");
    conv(8'h06, 1'b0, 1, "not06");
    conv(8'h80, 1'b1, 1, "neg80");
    conv(8'h00, 1'b1, 1, "neg00");
    conv(8'h80, 1'b0, 1, "not80");

    // inicio held high, operand scrambled mid-conversion, back-to-back restart
    dato_in = 8'h35;
    modo    = 1'b1;
    inicio  = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      dato_in = 8'($urandom);
      modo    = 1'($urandom);
      tick();
    end
    chk("b2b_listo1", listo, 1);
    chk("b2b_dato1", dato_out, 8'hCB);
    chk("b2b_desb1", desborde, 0);
    dato_in = 8'h5A;
    modo    = 1'b0;
    cyc  = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      cyc++;
      dato_in = 8'($urandom);
      modo    = 1'($urandom);
      if (listo) seen = 1;
    end
    chk("b2b_period", cyc, 9);
    chk("b2b_dato2", dato_out, 8'hA5);
    inicio = 1'b0;
    tick();
    tick();
    chk("b2b_idle", ocupado, 0);

    // asynchronous reset four cycles into a conversion
    dato_in = 8'h3C;
    modo    = 1'b1;
    inicio  = 1'b1;
    tick();
    inicio  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_ocupado_before", ocupado, 1);
    rst = 1'b1;
    #1;
    chk("arst_ocupado", ocupado, 0);
    chk("arst_listo", listo, 0);
    chk("arst_dato_out", dato_out, 0);
    chk("arst_desborde", desborde, 0);
    tick();
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (listo || ocupado) seen = 1;
    end
    chk("arst_no_listo", seen, 0);
    conv(8'h3C, 1'b1, 1, "post_rst");

    for (int n = 0; n < 1000; n++) begin
      conv(8'($urandom), 1'($urandom), 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
